// File: rtl/frame_energy_pkg.sv
// Shared types and constants for the frame energy meter.
// The optional peak path is enabled with the FRAME_ENERGY_PEAK_EN macro.
package frame_energy_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned SQ_W       = 32;
    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSquare,
        StAccum,
        StDump
    } fem_state_e;

    // |x| with the most negative code saturated so the result fits in a signed range.
    function automatic logic [SAMPLE_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] x);
        if (!x[SAMPLE_W-1]) begin
            return x;
        end
        if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
        return -x;
    endfunction

endpackage

// File: rtl/lr_clk_oneshot.sv
// Synchronises the codec lr_clk into clk and emits a one-cycle strobe per rising edge.
// A level already high when reset releases is ignored until lr_clk has been seen low.
module lr_clk_oneshot
    import frame_energy_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic lr_clk,
    output logic strobe
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic [SYNC_DEPTH-1:0] fill_q;
    logic                  prev_q;
    logic                  armed_q, armed_d;
    logic                  strobe_q, strobe_d;

    // fill_q marks when sync_q holds genuine lr_clk samples rather than reset values
    always_comb begin
        armed_d  = armed_q | (fill_q[SYNC_DEPTH-1] & ~sync_q[SYNC_DEPTH-1]);
        strobe_d = armed_q & sync_q[SYNC_DEPTH-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            fill_q   <= '0;
            prev_q   <= 1'b0;
            armed_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_DEPTH-2:0], lr_clk};
            fill_q   <= {fill_q[SYNC_DEPTH-2:0], 1'b1};
            prev_q   <= sync_q[SYNC_DEPTH-1];
            armed_q  <= armed_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/frame_energy_meter.sv
// Per-window mean-square energy meter with optional peak magnitude.
// Define FRAME_ENERGY_PEAK_EN to build the peak path; otherwise peak_out is tied to 0.
module frame_energy_meter
    import frame_energy_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lr_clk,
    input  logic [SAMPLE_W-1:0] audio_in,
    output logic [SQ_W-1:0]     energy_out,
    output logic                energy_valid,
    output logic [SAMPLE_W-1:0] peak_out,
    output logic                overrun
);

    localparam int unsigned ACC_W = SQ_W + WINDOW_LOG2;

    logic                   strobe;
    fem_state_e             state_q, state_d;
    logic [SAMPLE_W-1:0]    hold_q, hold_d;
    logic [SQ_W-1:0]        sq_q, sq_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic [SQ_W-1:0]        energy_q, energy_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic signed [SQ_W-1:0] hold_ext;
`ifdef FRAME_ENERGY_PEAK_EN
    logic [SAMPLE_W-1:0]    mag_q, mag_d;
    logic [SAMPLE_W-1:0]    peak_q, peak_d;
    logic [SAMPLE_W-1:0]    peak_out_q, peak_out_d;
`endif

    lr_clk_oneshot u_oneshot (
        .clk    (clk),
        .reset  (reset),
        .lr_clk (lr_clk),
        .strobe (strobe)
    );

    assign hold_ext = SQ_W'($signed(hold_q));

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        sq_d      = sq_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        energy_d  = energy_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
`ifdef FRAME_ENERGY_PEAK_EN
        mag_d      = mag_q;
        peak_d     = peak_q;
        peak_out_d = peak_out_q;
`endif

        // A strobe always refreshes hold; the FSM only picks it up from idle.
        if (strobe) begin
            hold_d = audio_in;
            if (state_q != StIdle) begin
                overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (strobe) begin
                    state_d = StSquare;
                end
            end
            StSquare: begin
                sq_d    = hold_ext * hold_ext;
`ifdef FRAME_ENERGY_PEAK_EN
                mag_d   = sat_abs(hold_q);
`endif
                state_d = StAccum;
            end
            StAccum: begin
                acc_d = acc_q + ACC_W'(sq_q);
                cnt_d = cnt_q + 1'b1;
`ifdef FRAME_ENERGY_PEAK_EN
                if (mag_q > peak_q) begin
                    peak_d = mag_q;
                end
`endif
                state_d = (&cnt_q) ? StDump : StIdle;
            end
            StDump: begin
                energy_d = SQ_W'(acc_q >> WINDOW_LOG2);
                valid_d  = 1'b1;
                acc_d    = '0;
`ifdef FRAME_ENERGY_PEAK_EN
                peak_out_d = peak_q;
                peak_d     = '0;
`endif
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            sq_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            energy_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            sq_q      <= sq_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            energy_q  <= energy_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef FRAME_ENERGY_PEAK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_q      <= '0;
            peak_q     <= '0;
            peak_out_q <= '0;
        end else begin
            mag_q      <= mag_d;
            peak_q     <= peak_d;
            peak_out_q <= peak_out_d;
        end
    end

    assign peak_out = peak_out_q;
`else
    assign peak_out = '0;
`endif

    assign energy_out   = energy_q;
    assign energy_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_frame_energy_meter.sv
// Self-checking bench for frame_energy_meter with a 4-sample window.
// Builds with or without FRAME_ENERGY_PEAK_EN; peak expectations follow the macro.
module tb_frame_energy_meter;

    localparam int unsigned WL = 2;
    localparam int          WIN = 4;
`ifdef FRAME_ENERGY_PEAK_EN
    localparam int PEAK_EN = 1;
`else
    localparam int PEAK_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lr_clk = 1'b0;
    logic [15:0] audio_in = '0;
    logic [31:0] energy_out;
    logic        energy_valid;
    logic [15:0] peak_out;
    logic        overrun;

    frame_energy_meter #(
        .WINDOW_LOG2 (WL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lr_clk       (lr_clk),
        .audio_in     (audio_in),
        .energy_out   (energy_out),
        .energy_valid (energy_valid),
        .peak_out     (peak_out),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    bit checking = 0;

    // Model state: samples of the open window, the outputs it last produced,
    // and a scheduled update for the window currently completing.
    int     win_q[$];
    int     last_acc = -100;
    bit     last_bnd = 0;
    longint cur_e = 0, cur_p = 0, nxt_e = 0, nxt_p = 0;
    bit     pend = 0;
    int     pend_cyc = 0;
    int     ov_cyc = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint sat_mag(input int v);
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        win_q.delete();
        last_acc = -100;
        last_bnd = 0;
        cur_e = 0;
        cur_p = 0;
        pend = 0;
        ov_cyc = -1;
    endtask

    // A sample whose rise lands within the datapath's busy time of the previous accepted
    // one is dropped and raises overrun four cycles later.
    task automatic model_sample(input int v);
        int     d;
        longint s, pk;
        d = cyc - last_acc;
        if (d >= 1 && d <= (last_bnd ? 3 : 2)) begin
            if (ov_cyc < 0) ov_cyc = cyc + 4;
        end else begin
            last_acc = cyc;
            win_q.push_back(v);
            last_bnd = 0;
            if (win_q.size() == WIN) begin
                if (pend) begin
                    cur_e = nxt_e;
                    cur_p = nxt_p;
                end
                s  = 0;
                pk = 0;
                foreach (win_q[i]) begin
                    s += longint'(win_q[i]) * longint'(win_q[i]);
                    if (sat_mag(win_q[i]) > pk) pk = sat_mag(win_q[i]);
                end
                nxt_e    = s / WIN;
                nxt_p    = PEAK_EN ? pk : 0;
                pend     = 1;
                pend_cyc = cyc + 7;
                last_bnd = 1;
                win_q.delete();
            end
        end
    endtask

    always @(negedge clk) begin
        bit     ev;
        longint ee, ep;
        if (checking) begin
            ev = pend && (cyc == pend_cyc);
            ee = (pend && cyc >= pend_cyc) ? nxt_e : cur_e;
            ep = (pend && cyc >= pend_cyc) ? nxt_p : cur_p;
            chk("energy_valid", energy_valid, ev);
            chk("energy_out", energy_out, ee);
            chk("peak_out", peak_out, ep);
            chk("overrun", overrun, (ov_cyc >= 0 && cyc >= ov_cyc));
            if (energy_valid) vcount++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input int v);
        audio_in = 16'(v);
        lr_clk   = 1'b1;
        model_sample(v);
        tick(5);
        lr_clk = 1'b0;
        tick(5);
    endtask

    initial begin
        int v0;
        model_reset();
        tick(3);
        checking = 1;
        chk("rst_energy", energy_out, 0);
        chk("rst_valid", energy_valid, 0);
        chk("rst_peak", peak_out, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b1;
        tick(4);

        v0 = vcount;
        repeat (4) send(1000);
        chk("s1_energy", energy_out, 1000000);
        chk("s1_peak", peak_out, PEAK_EN ? 1000 : 0);
        chk("s1_model_energy", nxt_e, 1000000);
        chk("s1_pulses", vcount - v0, 1);

        v0 = vcount;
        send(100);
        send(-100);
        send(100);
        chk("s2_no_early_pulse", vcount - v0, 0);
        send(-100);
        chk("s2_energy", energy_out, 10000);
        chk("s2_peak", peak_out, PEAK_EN ? 100 : 0);
        chk("s2_pulses", vcount - v0, 1);

        repeat (4) send(-32768);
        chk("s3_energy", energy_out, 1073741824);
        chk("s3_peak", peak_out, PEAK_EN ? 32767 : 0);
        chk("s3_model_energy", nxt_e, 1073741824);

        // Reset mid-window with lr_clk held high across release.
        send(7);
        send(7);
        audio_in = 16'd500;
        lr_clk   = 1'b1;
        reset    = 1'b0;
        model_reset();
        tick(3);
        chk("s4_rst_energy", energy_out, 0);
        chk("s4_rst_peak", peak_out, 0);
        chk("s4_rst_valid", energy_valid, 0);
        reset = 1'b1;
        tick(5);
        lr_clk = 1'b0;
        tick(5);
        v0 = vcount;
        repeat (4) send(10);
        chk("s4_energy", energy_out, 100);
        chk("s4_peak", peak_out, PEAK_EN ? 10 : 0);
        chk("s4_pulses", vcount - v0, 1);

        // Two rises two cycles apart: the second is dropped and overrun sticks.
        audio_in = 16'd5;
        lr_clk   = 1'b1;
        model_sample(5);
        tick(1);
        lr_clk = 1'b0;
        tick(1);
        lr_clk = 1'b1;
        model_sample(5);
        tick(5);
        lr_clk = 1'b0;
        tick(5);
        chk("s5_overrun_set", overrun, 1);
        repeat (3) send(5);
        chk("s5_energy", energy_out, 25);
        chk("s5_peak", peak_out, PEAK_EN ? 5 : 0);
        repeat (4) send(3);
        chk("s5_energy2", energy_out, 9);
        chk("s5_overrun_held", overrun, 1);
        reset = 1'b0;
        model_reset();
        tick(2);
        chk("s5_overrun_cleared", overrun, 0);
        reset = 1'b1;
        tick(3);

        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
